// File: rtl/frogger_pkg.sv
// Shared Frogger playfield constants, lane defaults and the lane FSM state type.
package frogger_pkg;

  localparam int TILE_SIZE      = 32;
  localparam int H_VISIBLE_AREA = 640;
  localparam int V_VISIBLE_AREA = 480;

  localparam int C_LINE_1_Y = 352;
  localparam int C_LINE_2_Y = 320;
  localparam int C_LINE_3_Y = 288;
  localparam int C_LINE_4_Y = 256;

  localparam logic [15:0] C_LANE_SPEED   = 16'h3121;
  localparam logic [3:0]  C_LANE_REVERSE = 4'b1010;

  localparam int C_LANE_0_START = 0;
  localparam int C_LANE_1_START = 160;
  localparam int C_LANE_2_START = 320;
  localparam int C_LANE_3_START = 480;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_WRITE,
    S_COMMIT
  } t_lane_state;

endpackage

// File: rtl/lane_step_calc.sv
// Combinational single-lane mover: advances x by step in either direction
// and wraps around the visible width, flagging when a wrap happened.
module lane_step_calc
  import frogger_pkg::*;
#(
  parameter int WRAP_WIDTH = H_VISIBLE_AREA
) (
  input  logic [9:0] x,
  input  logic [4:0] step,
  input  logic       reverse,
  output logic [9:0] x_next,
  output logic       wrap
);

  localparam logic [10:0] C_WRAP = 11'(WRAP_WIDTH);

  logic [10:0] x_ext;
  logic [10:0] step_ext;
  logic [10:0] fwd_sum;

  // 11-bit arithmetic keeps x + step and x + width - step from overflowing
  always_comb begin
    x_ext    = {1'b0, x};
    step_ext = {6'b000000, step};
    fwd_sum  = x_ext + step_ext;
    x_next   = '0;
    wrap     = 1'b0;
    if (reverse) begin
      if (x_ext < step_ext) begin
        wrap   = 1'b1;
        x_next = 10'(x_ext + C_WRAP - step_ext);
      end else begin
        x_next = 10'(x_ext - step_ext);
      end
    end else begin
      if (fwd_sum >= C_WRAP) begin
        wrap   = 1'b1;
        x_next = 10'(fwd_sum - C_WRAP);
      end else begin
        x_next = fwd_sum[9:0];
      end
    end
  end

endmodule

// File: rtl/car_lane_controller.sv
// Four-lane car position generator for the Frogger playfield.
// One shared lane_step_calc is time-multiplexed over the lanes; results are
// staged in shadow registers and committed to the outputs in a single edge so
// the sprite stage never sees a half-updated set of lanes.
// Optional feature macro: CAR_LANE_LEVEL_SPEEDUP_EN (adds i_Level to every
// lane speed; when undefined i_Level is ignored).
module car_lane_controller #(
  parameter int          TILE_SIZE      = frogger_pkg::TILE_SIZE,
  parameter int          H_VISIBLE_AREA = frogger_pkg::H_VISIBLE_AREA,
  parameter int          FRAME_DIV      = 2,
  parameter logic [15:0] LANE_SPEED     = frogger_pkg::C_LANE_SPEED,
  parameter logic [3:0]  LANE_REVERSE   = frogger_pkg::C_LANE_REVERSE,
  parameter int          LANE_0_START   = frogger_pkg::C_LANE_0_START,
  parameter int          LANE_1_START   = frogger_pkg::C_LANE_1_START,
  parameter int          LANE_2_START   = frogger_pkg::C_LANE_2_START,
  parameter int          LANE_3_START   = frogger_pkg::C_LANE_3_START
) (
  input  logic       i_Clk,
  input  logic       i_Rst_N,
  input  logic       i_Frame_Tick,
  input  logic       i_Enable,
  input  logic       i_Restart,
  input  logic [2:0] i_Level,
  output logic [9:0] o_Car_1X_Position,
  output logic [9:0] o_Car_2X_Position,
  output logic [9:0] o_Car_3X_Position,
  output logic [9:0] o_Car_4X_Position,
  output logic [3:0] o_Reverse,
  output logic       o_Busy,
  output logic [3:0] o_Wrap_Pulse,
  output logic       o_Overrun
);

  import frogger_pkg::*;

  // Every start position must leave room for a whole car sprite on screen
  localparam bit C_CFG_OK = (FRAME_DIV >= 1) && (FRAME_DIV <= 15) &&
                            (LANE_0_START >= 0) && (LANE_0_START <= H_VISIBLE_AREA - TILE_SIZE) &&
                            (LANE_1_START >= 0) && (LANE_1_START <= H_VISIBLE_AREA - TILE_SIZE) &&
                            (LANE_2_START >= 0) && (LANE_2_START <= H_VISIBLE_AREA - TILE_SIZE) &&
                            (LANE_3_START >= 0) && (LANE_3_START <= H_VISIBLE_AREA - TILE_SIZE);

  generate
    if (!C_CFG_OK) begin : g_cfg_error
      $error("car_lane_controller: FRAME_DIV or lane start position out of range");
    end
  endgenerate

  localparam logic [3:0] C_DIV_LAST = 4'(FRAME_DIV - 1);

  t_lane_state r_state;
  logic [1:0]  r_lane;
  logic [3:0]  r_div;
  logic [9:0]  r_shadow [4];
  logic [9:0]  r_pos [4];
  logic [9:0]  r_cand;
  logic        r_cand_wrap;
  logic [3:0]  r_wrap_flags;
  logic        r_busy;
  logic [3:0]  r_wrap_pulse;
  logic        r_overrun;

  logic [3:0]  lane_base;
  logic [4:0]  lane_step;
  logic [9:0]  calc_x_next;
  logic        calc_wrap;

`ifdef CAR_LANE_LEVEL_SPEEDUP_EN
  logic [2:0]  r_level;
`else
  logic        unused_level;
  assign unused_level = ^i_Level;
`endif

  // Step for the lane currently being processed: its base speed, plus level when enabled
  always_comb begin
    lane_base = LANE_SPEED[{r_lane, 2'b00} +: 4];
`ifdef CAR_LANE_LEVEL_SPEEDUP_EN
    lane_step = {1'b0, lane_base} + {2'b00, r_level};
`else
    lane_step = {1'b0, lane_base};
`endif
  end

  lane_step_calc #(
    .WRAP_WIDTH (H_VISIBLE_AREA)
  ) u_step_calc (
    .x       (r_shadow[r_lane]),
    .step    (lane_step),
    .reverse (LANE_REVERSE[r_lane]),
    .x_next  (calc_x_next),
    .wrap    (calc_wrap)
  );

  // Frame divider plus IDLE -> (CALC, WRITE) x4 -> COMMIT sequencer; reset and restart share one load path
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_N || i_Restart) begin
      r_state      <= S_IDLE;
      r_lane       <= 2'd0;
      r_div        <= 4'd0;
      r_shadow[0]  <= 10'(LANE_0_START);
      r_shadow[1]  <= 10'(LANE_1_START);
      r_shadow[2]  <= 10'(LANE_2_START);
      r_shadow[3]  <= 10'(LANE_3_START);
      r_pos[0]     <= 10'(LANE_0_START);
      r_pos[1]     <= 10'(LANE_1_START);
      r_pos[2]     <= 10'(LANE_2_START);
      r_pos[3]     <= 10'(LANE_3_START);
      r_cand       <= '0;
      r_cand_wrap  <= 1'b0;
      r_wrap_flags <= '0;
      r_busy       <= 1'b0;
      r_wrap_pulse <= '0;
      r_overrun    <= 1'b0;
`ifdef CAR_LANE_LEVEL_SPEEDUP_EN
      r_level      <= '0;
`endif
    end else begin
      r_wrap_pulse <= '0;
      if (i_Frame_Tick && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (i_Frame_Tick && i_Enable) begin
            if (r_div == C_DIV_LAST) begin
              r_div   <= 4'd0;
              r_lane  <= 2'd0;
              r_busy  <= 1'b1;
              r_state <= S_CALC;
`ifdef CAR_LANE_LEVEL_SPEEDUP_EN
              r_level <= i_Level;
`endif
            end else begin
              r_div <= r_div + 4'd1;
            end
          end
        end
        S_CALC: begin
          r_cand      <= calc_x_next;
          r_cand_wrap <= calc_wrap;
          r_state     <= S_WRITE;
        end
        S_WRITE: begin
          r_shadow[r_lane]     <= r_cand;
          r_wrap_flags[r_lane] <= r_cand_wrap;
          if (r_lane == 2'd3) begin
            r_state <= S_COMMIT;
          end else begin
            r_lane  <= r_lane + 2'd1;
            r_state <= S_CALC;
          end
        end
        S_COMMIT: begin
          r_pos        <= r_shadow;
          r_wrap_pulse <= r_wrap_flags;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_Car_1X_Position = r_pos[0];
  assign o_Car_2X_Position = r_pos[1];
  assign o_Car_3X_Position = r_pos[2];
  assign o_Car_4X_Position = r_pos[3];
  assign o_Reverse         = LANE_REVERSE;
  assign o_Busy            = r_busy;
  assign o_Wrap_Pulse      = r_wrap_pulse;
  assign o_Overrun         = r_overrun;

endmodule

// File: tb/tb_car_lane_controller.sv
// Self-checking bench for car_lane_controller with a position-level lane model.
module tb_car_lane_controller;

  localparam int          FRAME_DIV = 2;
  localparam int          H_WIDTH   = 640;
  localparam logic [15:0] SPEED     = 16'h3121;
  localparam logic [3:0]  REV       = 4'b1010;

  int starts [4] = '{0, 160, 320, 480};

  logic       i_Clk = 1'b0;
  logic       i_Rst_N = 1'b0;
  logic       i_Frame_Tick = 1'b0;
  logic       i_Enable = 1'b0;
  logic       i_Restart = 1'b0;
  logic [2:0] i_Level = 3'd0;
  logic [9:0] o_Car_1X_Position;
  logic [9:0] o_Car_2X_Position;
  logic [9:0] o_Car_3X_Position;
  logic [9:0] o_Car_4X_Position;
  logic [3:0] o_Reverse;
  logic       o_Busy;
  logic [3:0] o_Wrap_Pulse;
  logic       o_Overrun;

  int n_compared = 0;
  int n_mismatched = 0;

  int       m_pos [4];
  int       m_next [4];
  int       m_div;
  bit       m_pending;
  bit [3:0] m_wrap;
  bit [3:0] wraps_seen = '0;

  car_lane_controller #(
    .TILE_SIZE      (32),
    .H_VISIBLE_AREA (H_WIDTH),
    .FRAME_DIV      (FRAME_DIV),
    .LANE_SPEED     (SPEED),
    .LANE_REVERSE   (REV),
    .LANE_0_START   (0),
    .LANE_1_START   (160),
    .LANE_2_START   (320),
    .LANE_3_START   (480)
  ) dut (
    .i_Clk             (i_Clk),
    .i_Rst_N           (i_Rst_N),
    .i_Frame_Tick      (i_Frame_Tick),
    .i_Enable          (i_Enable),
    .i_Restart         (i_Restart),
    .i_Level           (i_Level),
    .o_Car_1X_Position (o_Car_1X_Position),
    .o_Car_2X_Position (o_Car_2X_Position),
    .o_Car_3X_Position (o_Car_3X_Position),
    .o_Car_4X_Position (o_Car_4X_Position),
    .o_Reverse         (o_Reverse),
    .o_Busy            (o_Busy),
    .o_Wrap_Pulse      (o_Wrap_Pulse),
    .o_Overrun         (o_Overrun)
  );

  always #5 i_Clk = ~i_Clk;

  function automatic logic [9:0] dut_pos(input int lane);
    case (lane)
      0:       return o_Car_1X_Position;
      1:       return o_Car_2X_Position;
      2:       return o_Car_3X_Position;
      default: return o_Car_4X_Position;
    endcase
  endfunction

  // Frame-level model: every FRAME_DIV enabled ticks all lanes move by their step modulo the width
  function automatic void model_tick(input int level);
    int base;
    int step;
    if (!i_Enable) return;
    m_div++;
    if (m_div == FRAME_DIV) begin
      m_div = 0;
      m_pending = 1'b1;
      for (int l = 0; l < 4; l++) begin
        base = int'((SPEED >> (4 * l)) & 16'h000F);
`ifdef CAR_LANE_LEVEL_SPEEDUP_EN
        step = base + level;
`else
        step = base + 0 * level;
`endif
        if (REV[l]) begin
          m_wrap[l] = (m_pos[l] < step);
          m_next[l] = (m_pos[l] - step + H_WIDTH) % H_WIDTH;
        end else begin
          m_wrap[l] = (m_pos[l] + step >= H_WIDTH);
          m_next[l] = (m_pos[l] + step) % H_WIDTH;
        end
      end
    end
  endfunction

  function automatic void model_restart();
    for (int l = 0; l < 4; l++) m_pos[l] = starts[l];
    m_div = 0;
    m_pending = 1'b0;
  endfunction

  function automatic void model_commit();
    for (int l = 0; l < 4; l++) m_pos[l] = m_next[l];
    m_pending = 1'b0;
  endfunction

  task automatic step_clk();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic pulse_tick();
    i_Frame_Tick = 1'b1;
    step_clk();
    i_Frame_Tick = 1'b0;
  endtask

  // Waits (bounded) for the sequence to finish; reports busy length and whether outputs moved early
  task automatic wait_idle(output int busy_cycles, output bit moved_early);
    logic [9:0] snap [4];
    for (int l = 0; l < 4; l++) snap[l] = dut_pos(l);
    busy_cycles = 0;
    moved_early = 1'b0;
    while (o_Busy && busy_cycles < 30) begin
      for (int l = 0; l < 4; l++) if (dut_pos(l) !== snap[l]) moved_early = 1'b1;
      step_clk();
      busy_cycles++;
    end
  endtask

  task automatic test_reset();
    i_Rst_N = 1'b0;
    i_Enable = 1'b1;
    repeat (3) step_clk();
    model_restart();
    for (int l = 0; l < 4; l++) begin
      n_compared++;
      if (dut_pos(l) !== 10'(starts[l])) begin
        n_mismatched++;
        $display("[TB] FAIL reset_pos lane %0d: got %0d expected %0d", l, dut_pos(l), starts[l]);
      end
    end
    n_compared++;
    if ({o_Reverse, o_Busy, o_Wrap_Pulse, o_Overrun} !== {REV, 1'b0, 4'b0000, 1'b0}) begin
      n_mismatched++;
      $display("[TB] FAIL reset_flags: got rev=%b busy=%b wrap=%b ovr=%b expected rev=%b rest 0",
               o_Reverse, o_Busy, o_Wrap_Pulse, o_Overrun, REV);
    end
    i_Rst_N = 1'b1;
    step_clk();
  endtask

  task automatic test_first_update();
    int cyc;
    bit early;
    int expect_pos [4] = '{1, 158, 321, 477};
    i_Level = 3'd0;
    pulse_tick();
    model_tick(0);
    n_compared++;
    if (o_Busy !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL first_tick_idle: busy got %b expected 0", o_Busy);
    end
    pulse_tick();
    model_tick(0);
    n_compared++;
    if (o_Busy !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL second_tick_busy: busy got %b expected 1", o_Busy);
    end
    wait_idle(cyc, early);
    n_compared++;
    if (cyc !== 9) begin
      n_mismatched++;
      $display("[TB] FAIL busy_length: got %0d cycles expected 9", cyc);
    end
    n_compared++;
    if (early !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL atomic_commit: outputs moved before commit (got 1 expected 0)");
    end
    for (int l = 0; l < 4; l++) begin
      n_compared++;
      if (dut_pos(l) !== 10'(expect_pos[l])) begin
        n_mismatched++;
        $display("[TB] FAIL first_pos lane %0d: got %0d expected %0d", l, dut_pos(l), expect_pos[l]);
      end
    end
    model_commit();
    step_clk();
    n_compared++;
    if (o_Wrap_Pulse !== 4'b0000) begin
      n_mismatched++;
      $display("[TB] FAIL first_wrap: got %b expected 0000", o_Wrap_Pulse);
    end
  endtask

  task automatic test_enable_pause();
    int cyc;
    bit early;
    pulse_tick();
    model_tick(int'(i_Level));
    i_Enable = 1'b0;
    for (int t = 0; t < 6; t++) begin
      pulse_tick();
      model_tick(int'(i_Level));
      step_clk();
      n_compared++;
      if (o_Busy !== 1'b0) begin
        n_mismatched++;
        $display("[TB] FAIL pause_busy tick %0d: got %b expected 0", t, o_Busy);
      end
    end
    for (int l = 0; l < 4; l++) begin
      n_compared++;
      if (dut_pos(l) !== 10'(m_pos[l])) begin
        n_mismatched++;
        $display("[TB] FAIL pause_pos lane %0d: got %0d expected %0d", l, dut_pos(l), m_pos[l]);
      end
    end
    i_Enable = 1'b1;
    pulse_tick();
    model_tick(int'(i_Level));
    n_compared++;
    if (o_Busy !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL pause_div_held: busy got %b expected 1", o_Busy);
    end
    wait_idle(cyc, early);
    for (int l = 0; l < 4; l++) begin
      n_compared++;
      if (dut_pos(l) !== 10'(m_next[l])) begin
        n_mismatched++;
        $display("[TB] FAIL pause_resume lane %0d: got %0d expected %0d", l, dut_pos(l), m_next[l]);
      end
    end
    model_commit();
    step_clk();
  endtask

  task automatic test_overrun();
    int cyc;
    bit early;
    pulse_tick();
    model_tick(int'(i_Level));
    pulse_tick();
    model_tick(int'(i_Level));
    repeat (3) step_clk();
    pulse_tick();
    n_compared++;
    if (o_Overrun !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL overrun_set: got %b expected 1", o_Overrun);
    end
    wait_idle(cyc, early);
    n_compared++;
    if (cyc !== 5) begin
      n_mismatched++;
      $display("[TB] FAIL overrun_seq_len: got %0d remaining busy cycles expected 5", cyc);
    end
    for (int l = 0; l < 4; l++) begin
      n_compared++;
      if (dut_pos(l) !== 10'(m_next[l])) begin
        n_mismatched++;
        $display("[TB] FAIL overrun_pos lane %0d: got %0d expected %0d", l, dut_pos(l), m_next[l]);
      end
    end
    model_commit();
    step_clk();
    n_compared++;
    if (o_Overrun !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL overrun_sticky: got %b expected 1", o_Overrun);
    end
    pulse_tick();
    model_tick(int'(i_Level));
    n_compared++;
    if (o_Busy !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL overrun_dropped: busy got %b expected 0", o_Busy);
    end
    pulse_tick();
    model_tick(int'(i_Level));
    wait_idle(cyc, early);
    model_commit();
    step_clk();
  endtask

  task automatic test_restart();
    int cyc;
    bit early;
    bit saw_activity;
    pulse_tick();
    model_tick(int'(i_Level));
    pulse_tick();
    model_tick(int'(i_Level));
    repeat (4) step_clk();
    i_Restart = 1'b1;
    step_clk();
    i_Restart = 1'b0;
    model_restart();
    n_compared++;
    if ({o_Busy, o_Overrun} !== 2'b00) begin
      n_mismatched++;
      $display("[TB] FAIL restart_flags: busy=%b ovr=%b expected 0 0", o_Busy, o_Overrun);
    end
    for (int l = 0; l < 4; l++) begin
      n_compared++;
      if (dut_pos(l) !== 10'(starts[l])) begin
        n_mismatched++;
        $display("[TB] FAIL restart_pos lane %0d: got %0d expected %0d", l, dut_pos(l), starts[l]);
      end
    end
    saw_activity = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step_clk();
      if (o_Busy || (o_Wrap_Pulse != 4'b0000) || (o_Car_1X_Position != 10'(starts[0])))
        saw_activity = 1'b1;
    end
    n_compared++;
    if (saw_activity !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL restart_no_commit: got activity 1 expected 0");
    end
    pulse_tick();
    model_tick(int'(i_Level));
    n_compared++;
    if (o_Busy !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL restart_div_clear: busy got %b expected 0", o_Busy);
    end
    pulse_tick();
    model_tick(int'(i_Level));
    wait_idle(cyc, early);
    for (int l = 0; l < 4; l++) begin
      n_compared++;
      if (dut_pos(l) !== 10'(m_next[l])) begin
        n_mismatched++;
        $display("[TB] FAIL restart_next lane %0d: got %0d expected %0d", l, dut_pos(l), m_next[l]);
      end
    end
    model_commit();
    step_clk();
  endtask

  task automatic test_random_run(input int n_updates);
    int cyc;
    bit early;
    int guard;
    for (int u = 0; u < n_updates; u++) begin
      guard = 0;
      while (!m_pending && guard < 40) begin
        i_Level  = 3'($urandom_range(0, 7));
        i_Enable = ($urandom_range(0, 5) != 0);
        pulse_tick();
        model_tick(int'(i_Level));
        guard++;
        if (!m_pending) begin
          n_compared++;
          if (o_Busy !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL rand_no_start upd %0d: busy got %b expected 0", u, o_Busy);
          end
          repeat ($urandom_range(0, 2)) step_clk();
        end
      end
      i_Enable = 1'b1;
      n_compared++;
      if (o_Busy !== 1'b1) begin
        n_mismatched++;
        $display("[TB] FAIL rand_start upd %0d: busy got %b expected 1", u, o_Busy);
      end
      wait_idle(cyc, early);
      n_compared++;
      if ({cyc, early} !== {32'd9, 1'b0}) begin
        n_mismatched++;
        $display("[TB] FAIL rand_timing upd %0d: got %0d cycles early=%b expected 9 and 0", u, cyc, early);
      end
      for (int l = 0; l < 4; l++) begin
        n_compared++;
        if (dut_pos(l) !== 10'(m_next[l])) begin
          n_mismatched++;
          $display("[TB] FAIL rand_pos upd %0d lane %0d: got %0d expected %0d", u, l, dut_pos(l), m_next[l]);
        end
      end
      n_compared++;
      if (o_Wrap_Pulse !== m_wrap) begin
        n_mismatched++;
        $display("[TB] FAIL rand_wrap upd %0d: got %b expected %b", u, o_Wrap_Pulse, m_wrap);
      end
      wraps_seen = wraps_seen | o_Wrap_Pulse;
      model_commit();
      step_clk();
      n_compared++;
      if (o_Wrap_Pulse !== 4'b0000) begin
        n_mismatched++;
        $display("[TB] FAIL rand_wrap_len upd %0d: got %b expected 0000", u, o_Wrap_Pulse);
      end
      repeat ($urandom_range(0, 2)) step_clk();
    end
    n_compared++;
    if (wraps_seen !== 4'b1111) begin
      n_mismatched++;
      $display("[TB] FAIL wrap_coverage: lanes wrapped %b expected 1111", wraps_seen);
    end
  endtask

  initial begin
    test_reset();
    test_first_update();
    test_enable_pause();
    test_overrun();
    test_restart();
    test_random_run(700);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/car_lane_controller.md
# car_lane_controller

Generates the horizontal positions and direction flags of the four car lanes for the Frogger playfield. Once per frame, it advances each car by a lane speed. The speed is optionally scaled by level. Each car wraps around the 640-pixel visible width. All four positions are committed atomically during vertical blanking. The block sits directly upstream of the sprite display stage, which consumes `o_Car_nX_Position` and `o_Reverse`.

## Interface
Parameters:
- `TILE_SIZE`, 32: car sprite width in pixels. Used only for start-position checks.
- `H_VISIBLE_AREA`, 640: wrap modulus for X positions.
- `FRAME_DIV`, 2: frames per movement step. Legal range is 1–15.
- `LANE_SPEED`, 16'h3121: four 4-bit base speeds in pixels per step. Lane 0 is in bits [3:0].
- `LANE_REVERSE`, 4'b1010: per-lane direction. 1 means the car moves right-to-left.
- `LANE_0_START` … `LANE_3_START`, 0 / 160 / 320 / 480: reset and restart X positions.

Ports:
- `i_Clk`, in, 1: single clock (25 MHz pixel clock).
- `i_Rst_N`, in, 1: synchronous, active-low reset.
- `i_Frame_Tick`, in, 1: one-cycle pulse at the start of vertical blanking.
- `i_Enable`, in, 1: run when 1, pause when 0.
- `i_Restart`, in, 1: one-cycle pulse that reloads the start positions.
- `i_Level`, in, 3: difficulty level, 0–7.
- `o_Car_1X_Position` … `o_Car_4X_Position`, out, 10 each: committed lane 0–3 positions.
- `o_Reverse`, out, 4: equals `LANE_REVERSE`.
- `o_Busy`, out, 1: an update sequence is in progress.
- `o_Wrap_Pulse`, out, 4: one-cycle pulse per lane that wrapped in the committed update.
- `o_Overrun`, out, 1: sticky flag, set when `i_Frame_Tick` arrives while busy.

## Operation
- Each lane has a shadow X register and a committed output register.
- A frame counter `r_Div` (4 bits) advances on each accepted tick.
  - A tick is accepted when `i_Enable`=1 and the block is in IDLE.
  - When `r_Div` = `FRAME_DIV`-1, the counter returns to 0 and an update sequence starts.
  - Otherwise the counter increments and no sequence runs.
- State machine: IDLE → CALC(n) → WRITE(n), for n = 0..3 → COMMIT → IDLE.
  - CALC(n) registers the candidate position and wrap flag for lane n.
  - WRITE(n) stores the candidate into shadow n.
  - COMMIT copies all shadows to the outputs and pulses `o_Wrap_Pulse`.
- Step arithmetic:
  - step = base speed (4 bits) + `i_Level`, as a 5-bit zero-extended sum. The maximum step is 22.
  - `i_Level` is sampled once, at sequence start.
- Forward lane: x' = x + step. If x' ≥ `H_VISIBLE_AREA`, then x' −= `H_VISIBLE_AREA` and the wrap flag is set.
- Reverse lane: if x < step, then x' = x + `H_VISIBLE_AREA` − step and the wrap flag is set; otherwise x' = x − step.
- Intermediate arithmetic is 11 bits wide. Results always lie in 0..639.
- `i_Enable`=0: ticks are ignored, `r_Div` is held, and positions are held. A sequence already in progress still completes.
- `i_Restart`:
  - Has priority over everything except reset.
  - Aborts any sequence and returns to IDLE.
  - Loads the start positions into both the shadow and output registers.
  - Clears `r_Div` and `o_Overrun`.
- A tick arriving while not in IDLE is dropped and sets `o_Overrun`.
- Reset values:
  - Positions = `LANE_n_START`.
  - `o_Reverse` = `LANE_REVERSE`.
  - `o_Busy` = 0, `o_Wrap_Pulse` = 0, `o_Overrun` = 0.
  - `r_Div` = 0, state = IDLE.
- The restart effects take hold after the next clock edge.

## Timing
- A tick is sampled at edge T. CALC(0) runs in cycle T+1 and WRITE(3) in T+8. COMMIT is at edge T+9.
- New positions and `o_Wrap_Pulse` are visible from T+10. `o_Wrap_Pulse` lasts exactly one cycle.
- `o_Busy` is high from T+1 through the COMMIT cycle, T+9 inclusive.
- Outputs change only at COMMIT, restart or reset. The display never sees a mix of old and new lane positions.
- The total of 9 busy cycles fits easily within vertical blanking, which is about 36k cycles.
- If reset and restart are asserted together, reset wins. The results are identical in either case.

## Configuration
- `CAR_LANE_LEVEL_SPEEDUP_EN` defined: step = base + `i_Level`, as described above.
- `CAR_LANE_LEVEL_SPEEDUP_EN` undefined: step = base only. `i_Level` is unused, and the adder and level-sample register are removed.

## Structure
- Shared package `frogger_pkg` holds:
  - `TILE_SIZE`, `H_VISIBLE_AREA`, `V_VISIBLE_AREA`.
  - Lane Y constants `C_LINE_1_Y` … `C_LINE_4_Y`.
  - The default lane speed, reverse and start constants.
  - The state enum `t_lane_state`.
- One sub-module, `lane_step_calc`: combinational. Inputs are x, step and reverse; outputs are x' and the wrap flag. It is instantiated once and time-multiplexed across lanes.

## Test plan
- Reset, then 2 ticks (`FRAME_DIV`=2, `i_Level`=0) → positions 1 / 158 / 321 / 477. One update per 2 ticks; `o_Busy` high for 9 cycles.
- Lane 0 at 638, step 3 (`i_Level`=2) → commits 1 with `o_Wrap_Pulse`[0]=1 for one cycle.
- Lane 1 (reverse) at 1, base speed 2 → commits 639 with `o_Wrap_Pulse`[1]=1.
- Tick again at T+4 mid-sequence → `o_Overrun`=1; sequence completes normally; positions advance once.
- `i_Restart` at T+5 mid-sequence → state IDLE; positions 0 / 160 / 320 / 480; `o_Busy`=0; no COMMIT.
- `i_Enable`=0 for 6 ticks → positions and `r_Div` unchanged. With the macro undefined, `i_Level`=7 gives the same steps as `i_Level`=0.
